// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and
// default timing/stride parameters.
package fetch_pkg;

  localparam int TIMEOUT_CYCLES_DEF = 16;
  localparam int PC_STEP_DEF        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_FLUSH,
    S_ERR
  } fetch_state_t;

  // States in which a memory request is outstanding.
  function automatic logic is_waiting(fetch_state_t s);
    return (s == S_REQ) || (s == S_FLUSH);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: PC register port, instruction memory port,
// decode handshake, redirect request and error flag.
interface fetch_if;

  logic [31:0] pc_in;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_err;

  modport master (
    input  pc_in, imem_ack, imem_rdata, instr_ready, redirect, redirect_target,
    output pc_next, pc_write, imem_req, imem_addr, instr, instr_valid, imem_err
  );

  modport slave (
    output pc_in, imem_ack, imem_rdata, instr_ready, redirect, redirect_target,
    input  pc_next, pc_write, imem_req, imem_addr, instr, instr_valid, imem_err
  );

endinterface

// File: rtl/fetch_timeout.sv
// Wait counter for an outstanding memory request; expired flags the last
// permitted ack-less cycle.
module fetch_timeout
  import fetch_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (res || clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != W'(LIMIT - 1))) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues imem requests at the PC, hands words to
// decode over valid/ready, and advances or redirects the PC register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int PC_STEP        = PC_STEP_DEF
) (
  input  logic     clk,
  input  logic     res,
  fetch_if.master  bus
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  instr_reg;
  logic [31:0]  addr_q_reg;
  logic         err_reg;

  logic         capture;
  logic         err_set;
  logic         waiting;
  logic         expired;
  logic         wait_clear;
  logic         wait_enable;
  logic         req_c;
  logic         write_c;
  logic [31:0]  addr_c;
  logic [31:0]  pc_next_c;

  assign waiting     = is_waiting(state_reg);
  assign wait_enable = waiting && !bus.imem_ack;
  // Any ack or state change starts a fresh request, so the count restarts.
  assign wait_clear  = !waiting || bus.imem_ack || (state_next != state_reg);

  fetch_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .res     (res),
    .clear   (wait_clear),
    .enable  (wait_enable),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg  <= S_IDLE;
      instr_reg  <= '0;
      addr_q_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (capture)              instr_reg  <= bus.imem_rdata;
      if (state_reg == S_REQ)   addr_q_reg <= bus.pc_in;
      if (err_set)              err_reg    <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    err_set    = 1'b0;
    req_c      = 1'b0;
    addr_c     = '0;
    write_c    = 1'b0;
    pc_next_c  = '0;

    case (state_reg)
      S_IDLE: state_next = S_REQ;

      S_REQ: begin
        req_c  = 1'b1;
        addr_c = bus.pc_in;
        if (bus.redirect) begin
          write_c   = 1'b1;
          pc_next_c = bus.redirect_target;
        end
        if (bus.imem_ack) begin
          // A same-cycle redirect makes the returned word stale; refetch.
          if (!bus.redirect) begin
            capture    = 1'b1;
            state_next = S_VALID;
          end
        end else if (expired) begin
          err_set    = 1'b1;
          state_next = S_ERR;
        end else if (bus.redirect) begin
          state_next = S_FLUSH;
        end
      end

      S_FLUSH: begin
        // Keep the abandoned request on the bus until memory answers it.
        req_c  = 1'b1;
        addr_c = addr_q_reg;
        if (bus.redirect) begin
          write_c   = 1'b1;
          pc_next_c = bus.redirect_target;
        end
        if (bus.imem_ack) begin
          state_next = S_REQ;
        end else if (expired) begin
          err_set    = 1'b1;
          state_next = S_ERR;
        end
      end

      S_VALID: begin
        if (bus.redirect) begin
          write_c    = 1'b1;
          pc_next_c  = bus.redirect_target;
          state_next = S_REQ;
        end else if (bus.instr_ready) begin
          write_c    = 1'b1;
          pc_next_c  = bus.pc_in + 32'(PC_STEP);
          state_next = S_REQ;
        end
      end

      S_ERR: state_next = S_ERR;

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = addr_c;
  assign bus.pc_write    = write_c;
  assign bus.pc_next     = pc_next_c;
  assign bus.instr       = instr_reg;
  assign bus.instr_valid = (state_reg == S_VALID);
  assign bus.imem_err    = err_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: PC register and memory models plus an
// instruction scoreboard fed on memory acks and drained on decode handshakes.
module tb_fetch_unit;

  logic clk;
  logic res;
  logic [31:0] pc_reg;

  fetch_if bus ();

  fetch_unit #(.TIMEOUT_CYCLES(16), .PC_STEP(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus.master)
  );

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  int ack_delay   = 0;
  int wait_cnt    = 0;
  bit override_en = 0;
  bit doomed      = 0;
  logic [31:0] sb[$];
  logic [31:0] pw_log[$];
  int          hs_cyc[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (override_en) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // PC register written by the DUT.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (res) pc_reg <= '0;
    else if (bus.pc_write) pc_reg <= bus.pc_next;
  end
  assign bus.pc_in = pc_reg;

  // Memory: acks each request ack_delay cycles after it first appears.
  always @(posedge clk) begin
    #1;
    bus.imem_ack = 1'b0;
    if (res || !bus.imem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt >= ack_delay) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = mem_data(bus.imem_addr);
      wait_cnt       = 0;
    end else begin
      wait_cnt++;
    end
  end

  // Monitor: per-cycle PC-write expectation and scoreboard push/pop.
  always @(negedge clk) begin
    logic hs;
    logic exp_pw;
    hs     = bus.instr_valid && bus.instr_ready;
    exp_pw = bus.redirect || hs;
    check_eq("pc_write", 32'(bus.pc_write), 32'(exp_pw));
    if (bus.redirect)  check_eq("pc_next_redirect", bus.pc_next, bus.redirect_target);
    else if (hs)       check_eq("pc_next_step", bus.pc_next, pc_reg + 32'd4);
    if (bus.pc_write) pw_log.push_back(bus.pc_next);
    if (hs) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
      else                check_eq("instr", bus.instr, sb.pop_front());
    end else if (bus.instr_valid && bus.redirect && sb.size() > 0) begin
      void'(sb.pop_front());
    end
    if (bus.imem_req && bus.imem_ack) begin
      if (bus.redirect || doomed) begin
        doomed = 0;
      end else begin
        check_eq("imem_addr", bus.imem_addr, pc_reg);
        sb.push_back(mem_data(pc_reg));
      end
    end else if (bus.imem_req && bus.redirect) begin
      doomed = 1;
    end
    if (res) begin
      doomed = 0;
      sb.delete();
    end
  end

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.instr_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic drive(input logic rdy, input logic rdr, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    bus.instr_ready     = rdy;
    bus.redirect        = rdr;
    bus.redirect_target = tgt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    int n;
    res = 1'b1;
    bus.instr_ready     = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = '0;
    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_imem_addr", bus.imem_addr, 32'd0);
    check_eq("rst_pc_write", 32'(bus.pc_write), 32'd0);
    check_eq("rst_pc_next", bus.pc_next, 32'd0);
    check_eq("rst_instr", bus.instr, 32'd0);
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_imem_err", 32'(bus.imem_err), 32'd0);

    // Zero-wait memory, decode always ready.
    @(posedge clk);
    #1;
    res = 1'b0;
    bus.instr_ready = 1'b1;
    pw_log.delete();
    hs_cyc.delete();
    @(negedge clk);
    check_eq("idle_one_cycle", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("first_req", 32'(bus.imem_req), 32'd1);
    check_eq("first_addr", bus.imem_addr, 32'd0);
    repeat (6) @(negedge clk);
    drive(1'b0, 1'b0, '0);
    if (pw_log.size() >= 3 && hs_cyc.size() >= 3) begin
      check_eq("seq_pc_next0", pw_log[0], 32'h4);
      check_eq("seq_pc_next1", pw_log[1], 32'h8);
      check_eq("seq_pc_next2", pw_log[2], 32'hC);
      check_eq("seq_gap0", 32'(hs_cyc[1] - hs_cyc[0]), 32'd2);
      check_eq("seq_gap1", 32'(hs_cyc[2] - hs_cyc[1]), 32'd2);
    end else begin
      check_eq("seq_count", 32'(pw_log.size()), 32'd3);
    end
    wait_valid("valid_hold_seq");

    // Slow memory, decode stalled: word must hold with no PC write.
    ack_delay = 3;
    override_en = 1;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    wait_valid("valid_slow");
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_instr", bus.instr, 32'hDEAD_BEEF);
      check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
      @(negedge clk);
    end

    // Redirect during a pending request: stale data goes to flush.
    override_en = 0;
    ack_delay = 2;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 32'h100);
    drive(1'b0, 1'b0, '0);
    wait_valid("valid_after_flush");
    check_eq("redirect_instr", bus.instr, mem_data(32'h100));
    check_eq("redirect_pc", pc_reg, 32'h100);

    // Redirect together with ready wins over the sequential step.
    drive(1'b1, 1'b1, 32'h200);
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check_eq("valid_drop_ready_redir", 32'(bus.instr_valid), 32'd0);
    wait_valid("valid_0x200");
    check_eq("instr_0x200", bus.instr, mem_data(32'h200));

    // Redirect in VALID without ready, then PC wraparound.
    drive(1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, '0);
    @(negedge clk);
    check_eq("valid_drop_redir", 32'(bus.instr_valid), 32'd0);
    wait_valid("valid_top");
    check_eq("instr_top", bus.instr, mem_data(32'hFFFF_FFFC));
    drive(1'b1, 1'b0, '0);
    @(negedge clk);
    check_eq("wrap_pc_write", 32'(bus.pc_write), 32'd1);
    check_eq("wrap_pc_next", bus.pc_next, 32'h0);
    drive(1'b0, 1'b0, '0);
    wait_valid("valid_after_wrap");

    // Memory never answers: timeout into the error state.
    ack_delay = 1000;
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    n = 0;
    @(negedge clk);
    while (bus.imem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("timeout_len", 32'(n), 32'd16);
    check_eq("timeout_err", 32'(bus.imem_err), 32'd1);
    check_eq("timeout_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("err_sticky", 32'(bus.imem_err), 32'd1);
      check_eq("err_no_req", 32'(bus.imem_req), 32'd0);
      check_eq("err_no_valid", 32'(bus.instr_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("err_cleared", 32'(bus.imem_err), 32'd0);
    check_eq("err_rst_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the max cycles one imem request may wait for imem_ack.
REQ-002 Parameter PC_STEP, default 4, SHALL set the sequential PC increment in bytes.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 res  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 pc_in  input  32  SHALL be the current PC value from the PC register output.
REQ-006 pc_next  output  32  SHALL drive the PC register data input.
REQ-007 pc_write  output  1  SHALL drive the PC register write enable.
REQ-008 imem_req, imem_addr[31:0]  output  SHALL form the instruction-memory request.
REQ-009 imem_ack, imem_rdata[31:0]  input  SHALL form the memory response; ack is a one-cycle pulse.
REQ-010 instr[31:0], instr_valid  output; instr_ready  input  SHALL form the valid/ready handshake to decode.
REQ-011 redirect, redirect_target[31:0]  input  SHALL request a branch/jump to the target.
REQ-012 imem_err  output  1  SHALL be the sticky timeout error flag.

Function
REQ-013 FSM states SHALL be S_IDLE, S_REQ, S_VALID, S_FLUSH, S_ERR.
REQ-014 S_IDLE SHALL last exactly one cycle after res deasserts, then go to S_REQ.
REQ-015 In S_REQ, imem_req=1 and imem_addr=pc_in; addr_q SHALL capture pc_in every S_REQ cycle.
REQ-016 Ack may arrive in the first S_REQ cycle (zero-wait memory SHALL be supported).
REQ-017 On imem_ack in S_REQ without redirect, instr SHALL capture imem_rdata and the FSM SHALL go to S_VALID (instr_valid high the next cycle).
REQ-018 In S_VALID, instr_valid=1 and instr SHALL hold stable until instr_valid && instr_ready.
REQ-019 On acceptance, pc_write=1 for one cycle with pc_next=pc_in+PC_STEP (mod 2^32, 0xFFFFFFFC wraps to 0x00000000), then go to S_REQ.
REQ-020 Redirect in any of S_REQ/S_VALID/S_FLUSH SHALL assert pc_write=1 with pc_next=redirect_target that cycle; redirect SHALL take priority over acceptance.
REQ-021 Redirect in S_VALID SHALL drop instr_valid the next cycle and go to S_REQ.
REQ-022 Redirect in S_REQ with imem_ack the same cycle SHALL discard the data and stay in S_REQ.
REQ-023 Redirect in S_REQ without ack SHALL go to S_FLUSH; S_FLUSH SHALL keep imem_req=1, imem_addr=addr_q, discard data on ack, then go to S_REQ.
REQ-024 imem_req/imem_addr SHALL stay stable until ack; a request SHALL never be withdrawn except on timeout or reset.
REQ-025 A wait counter SHALL clear on entry to S_REQ/S_FLUSH and increment each cycle without ack; at TIMEOUT_CYCLES it SHALL set imem_err, drop imem_req and enter S_ERR.
REQ-026 S_ERR SHALL be exited only by res; in S_ERR pc_write, imem_req and instr_valid SHALL be 0.
REQ-027 pc_write SHALL be 0 in every cycle not covered by REQ-019/REQ-020.

Reset
REQ-028 While res=1: state=S_IDLE, imem_req=0, imem_addr=0, pc_write=0, pc_next=0, instr=0, instr_valid=0, imem_err=0, counter=0, addr_q=0.
REQ-029 res mid-transaction SHALL abandon the request; a later imem_ack for it SHALL be ignored outside S_REQ/S_FLUSH.

Structure
REQ-030 State encodings, PC_STEP and TIMEOUT_CYCLES defaults SHALL live in the shared package fetch_pkg.
REQ-031 The wait counter SHALL be a sub-module fetch_timeout (clear, enable, expired).

Verification
REQ-032 Reset, zero-wait memory, instr_ready=1: fetches from 0x0, 0x4, 0x8 each 2 cycles apart; pc_write pulses with pc_next=0x4, 0x8, 0xC.
REQ-033 Ack after 3 cycles, instr_ready low for 5 cycles: instr=0xDEADBEEF held with instr_valid=1, no pc_write until ready.
REQ-034 Redirect to 0x100 in S_REQ with ack delayed 2 cycles: pc_next=0x100 pulse, old data discarded, next imem_addr=0x100.
REQ-035 Redirect to 0x200 coinciding with instr_ready in S_VALID: pc_next=0x200, not pc_in+4.
REQ-036 No ack for 16 cycles: imem_err=1, imem_req=0, stays in S_ERR until res; res clears imem_err.
REQ-037 pc_in=0xFFFFFFFC accepted: pc_next=0x00000000.
